// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA address streamers.
package dma_pkg;

    localparam int DMA_ADDR_W      = 32;
    localparam int DMA_NUM_BYTES_W = 32;
    localparam int DMA_4KB         = 4096;

    // Transfer descriptor handed over by dma_fsm
    typedef struct packed {
        logic [DMA_ADDR_W-1:0]      src_addr;
        logic [DMA_ADDR_W-1:0]      dst_addr;
        logic [DMA_NUM_BYTES_W-1:0] num_bytes;
    } s_dma_desc_t;

    // Error report: valid pulse, originating streamer, offending address
    typedef struct packed {
        logic                  valid;
        logic                  src;
        logic [DMA_ADDR_W-1:0] addr;
    } s_dma_error_t;

    // Burst request towards the AXI master interface
    typedef struct packed {
        logic                  valid;
        logic [DMA_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
    } s_dma_axi_req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } dma_strm_st_t;

endpackage

// File: rtl/dma_burst_calc.sv
// dma_burst_calc: combinational burst length for the current streamer position.
// beats = min(MAX_BEATS, ceil(bytes_left/BYTES), beats up to next 4 KB page).
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int MAX_BEATS = 16,
    parameter int DATA_W    = 32
) (
    input  logic [11:0]                addr_lo_i,
    input  logic [DMA_NUM_BYTES_W-1:0] bytes_left_i,
    output logic [8:0]                 beats_o,
    output logic [7:0]                 len_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);

    logic [DMA_NUM_BYTES_W:0] beats_left_s;
    logic [12:0]              rem_4k_s;
    logic [12:0]              beats_4k_s;
    logic [8:0]               cand_s;

    // Minimum of the three beat limits; a partial last beat rounds up
    always_comb begin
        beats_left_s = ({1'b0, bytes_left_i} + (DMA_NUM_BYTES_W+1)'(BYTES - 1)) >> SZ;
        rem_4k_s     = 13'(DMA_4KB) - {1'b0, addr_lo_i};
        beats_4k_s   = rem_4k_s >> SZ;
        if (beats_left_s < (DMA_NUM_BYTES_W+1)'(MAX_BEATS)) begin
            cand_s = beats_left_s[8:0];
        end else begin
            cand_s = 9'(MAX_BEATS);
        end
        if ({4'b0000, cand_s} < beats_4k_s) begin
            beats_o = cand_s;
        end else begin
            beats_o = beats_4k_s[8:0];
        end
        len_o = 8'(beats_o - 9'd1);
    end

endmodule

// File: rtl/dma_streamer.sv
// dma_streamer: walks a descriptor address range and issues AXI burst requests.
// Optional feature macro: DMA_ALIGN_CHECK_EN (reject misaligned descriptors
// with an error pulse; otherwise the start address is truncated to a beat).
module dma_streamer
    import dma_pkg::*;
#(
    parameter int STREAM_TYPE = 0,
    parameter int MAX_BEATS   = 16,
    parameter int DATA_W      = 32
) (
    input  logic           clk,
    input  logic           rstn,
    input  s_dma_desc_t    dma_desc_i,
    input  logic           dma_stream_valid_i,
    output logic           dma_stream_done_o,
    output s_dma_error_t   dma_stream_err_o,
    output s_dma_axi_req_t dma_axi_req_o,
    input  logic           dma_axi_ready_i
);

    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam logic [DMA_ADDR_W-1:0]      ADDR_MASK  = DMA_ADDR_W'(BYTES - 1);
    localparam logic [DMA_NUM_BYTES_W-1:0] BYTES_MASK = DMA_NUM_BYTES_W'(BYTES - 1);

    dma_strm_st_t               st_q, st_d;
    logic [DMA_ADDR_W-1:0]      addr_q, addr_d;
    logic [DMA_NUM_BYTES_W-1:0] bytes_q, bytes_d;
    logic                       done_q, done_d;
    s_dma_error_t               err_q, err_d;

    logic [DMA_ADDR_W-1:0]      start_addr_s;
    logic [DMA_ADDR_W-1:0]      load_addr_s;
    logic                       bad_desc_s;
    logic [8:0]                 beats_s;
    logic [7:0]                 len_s;
    logic [DMA_NUM_BYTES_W-1:0] step_s;

    assign start_addr_s = (STREAM_TYPE != 0) ? dma_desc_i.dst_addr : dma_desc_i.src_addr;

`ifdef DMA_ALIGN_CHECK_EN
    assign bad_desc_s  = ((start_addr_s & ADDR_MASK) != '0) ||
                         ((dma_desc_i.num_bytes & BYTES_MASK) != '0);
    assign load_addr_s = start_addr_s;
`else
    assign bad_desc_s  = 1'b0;
    assign load_addr_s = start_addr_s & ~ADDR_MASK;
`endif

    dma_burst_calc #(
        .MAX_BEATS (MAX_BEATS),
        .DATA_W    (DATA_W)
    ) u_burst_calc (
        .addr_lo_i    (addr_q[11:0]),
        .bytes_left_i (bytes_q),
        .beats_o      (beats_s),
        .len_o        (len_s)
    );

    assign step_s = DMA_NUM_BYTES_W'(beats_s) << SZ;

    // Next-state, address/byte bookkeeping and done/err pulse generation
    always_comb begin
        st_d    = st_q;
        addr_d  = addr_q;
        bytes_d = bytes_q;
        done_d  = 1'b0;
        err_d   = '0;
        case (st_q)
            ST_IDLE: begin
                if (dma_stream_valid_i) begin
                    addr_d  = load_addr_s;
                    bytes_d = dma_desc_i.num_bytes;
                    if (bad_desc_s) begin
                        err_d.valid = 1'b1;
                        err_d.src   = (STREAM_TYPE != 0);
                        err_d.addr  = start_addr_s;
                        done_d      = 1'b1;
                        st_d        = ST_DONE;
                    end else if (dma_desc_i.num_bytes == '0) begin
                        done_d = 1'b1;
                        st_d   = ST_DONE;
                    end else begin
                        st_d = ST_REQ;
                    end
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!dma_stream_valid_i) begin
                    st_d = ST_IDLE;
                end else if (dma_axi_ready_i) begin
                    addr_d = addr_q + DMA_ADDR_W'(step_s);
                    if (step_s >= bytes_q) begin
                        bytes_d = '0;
                        done_d  = 1'b1;
                        st_d    = ST_DONE;
                    end else begin
                        bytes_d = bytes_q - step_s;
                        st_d    = ST_REQ;
                    end
                end else begin
                    st_d = ST_REQ;
                end
            end
            ST_DONE: begin
                if (!dma_stream_valid_i) begin
                    st_d = ST_IDLE;
                end else begin
                    st_d = ST_DONE;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q    <= ST_IDLE;
            addr_q  <= '0;
            bytes_q <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            st_q    <= st_d;
            addr_q  <= addr_d;
            bytes_q <= bytes_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Request fields are driven only while requesting so idle/reset reads all-zero
    always_comb begin
        dma_axi_req_o = '0;
        if (st_q == ST_REQ) begin
            dma_axi_req_o.valid = 1'b1;
            dma_axi_req_o.addr  = addr_q;
            dma_axi_req_o.len   = len_s;
            dma_axi_req_o.size  = 3'(SZ);
        end else begin
            dma_axi_req_o = '0;
        end
    end

    assign dma_stream_done_o = done_q;
    assign dma_stream_err_o  = err_q;

endmodule
